// File: rtl/srp_call_if.sv
// Host and kernel signal bundle for the call sequencer.
// slave: the sequencer side; master: the host/kernel environment side.
interface srp_call_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic                     arg_valid;
  logic                     arg_ready;
  logic signed [DATA_W-1:0] arg_data;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DATA_W-1:0] res_data;
  logic                     res_timeout;
  logic [CNT_W-1:0]         res_cycles;
  logic                     busy;
  logic                     k_r_enable;
  logic signed [DATA_W-1:0] k_init_i;
  logic                     k_w_enable;
  logic signed [DATA_W-1:0] k_result;

  modport slave (
    input  arg_valid, arg_data, res_ready, k_w_enable, k_result,
    output arg_ready, res_valid, res_data, res_timeout, res_cycles, busy,
           k_r_enable, k_init_i
  );

  modport master (
    output arg_valid, arg_data, res_ready, k_w_enable, k_result,
    input  arg_ready, res_valid, res_data, res_timeout, res_cycles, busy,
           k_r_enable, k_init_i
  );
endinterface

// File: rtl/srp_call_sequencer.sv
// Launcher for a synthesised kernel: queues call arguments, starts one
// kernel invocation at a time, waits for the done rising edge (or a
// timeout) and hands back result plus launch-to-done cycle count.
module srp_call_sequencer #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset,
  srp_call_if.slave  io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr, occ;
  logic                     full, empty, push, pop, rise, cap_rise, cap_to;
  logic                     wen_q;
  logic [CNT_W-1:0]         cnt, cnt_inc;
  logic signed [DATA_W-1:0] init_q, res_data_q;
  logic                     res_to_q;
  logic [CNT_W-1:0]         res_cyc_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ     = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (occ == FULL_OCC);
  assign push    = io.arg_valid && !full;
  assign rise    = io.k_w_enable && !wen_q;
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

  assign io.arg_ready   = !full;
  assign io.res_valid   = (state_q == DELIVER);
  assign io.res_data    = res_data_q;
  assign io.res_timeout = res_to_q;
  assign io.res_cycles  = res_cyc_q;
  assign io.busy        = (state_q != IDLE) || !empty;
  assign io.k_r_enable  = (state_q == LAUNCH);
  assign io.k_init_i    = init_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control strobes; a done edge wins over the
  // timeout if both land in the same cycle.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    cap_rise = 1'b0;
    cap_to   = 1'b0;
    case (state_q)
      IDLE:    if (!empty) begin pop = 1'b1; state_d = LAUNCH; end
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (rise) begin
          cap_rise = 1'b1;
          state_d  = DELIVER;
        end else if (cnt >= TO_LAST) begin
          cap_to  = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: if (io.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Argument storage; contents need no reset, pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io.arg_data;
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Kernel argument is loaded only on pop, so it stays put through WAIT.
  always_ff @(posedge clk) begin
    if (reset)    init_q <= '0;
    else if (pop) init_q <= mem[rd_ptr[AW-1:0]];
  end

  // Done-level history for edge detection and the saturating cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q <= 1'b0;
      cnt   <= '0;
    end else begin
      wen_q <= io.k_w_enable;
      if (state_q == LAUNCH)    cnt <= '0;
      else if (state_q == WAIT) cnt <= cnt_inc;
    end
  end

  // Result capture; held until the next call completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_q <= '0;
      res_to_q   <= 1'b0;
      res_cyc_q  <= '0;
    end else if (cap_rise) begin
      res_data_q <= io.k_result;
      res_to_q   <= 1'b0;
      res_cyc_q  <= cnt_inc;
    end else if (cap_to) begin
      res_data_q <= '0;
      res_to_q   <= 1'b1;
      res_cyc_q  <= TO_VAL;
    end
  end
endmodule

// File: tb/tb_srp_call_sequencer.sv
// Directed bench for srp_call_sequencer with a simple kernel model:
// result = -3*init, done level rises a programmable number of cycles
// after the start pulse.
module tb_srp_call_sequencer;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Kernel model knobs (cycle index counted from the start pulse cycle).
  bit k_pre_high = 1'b0;
  int k_drop_at  = 0;
  int k_rise_at  = 5;

  logic signed [63:0] rd_q[$];
  logic [31:0]        rc_q[$];
  logic               rt_q[$];
  logic signed [63:0] la_q[$];
  int                 lc_q[$];

  srp_call_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) io ();

  srp_call_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Kernel model.
  initial begin
    int kc;
    bit act;
    kc = 0;
    act = 1'b0;
    io.k_w_enable = 1'b0;
    io.k_result   = '0;
    forever begin
      @(negedge clk);
      io.k_result = -64'sd3 * io.k_init_i;
      if (io.k_r_enable) begin
        act = 1'b1;
        kc  = 0;
        io.k_w_enable = k_pre_high;
      end else if (act) begin
        kc = kc + 1;
        if (kc == k_drop_at) io.k_w_enable = 1'b0;
        if (kc == k_rise_at) io.k_w_enable = 1'b1;
      end
    end
  end

  // Record launches and result handshakes, sampled mid-low-phase.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (io.k_r_enable) begin
        la_q.push_back(io.k_init_i);
        lc_q.push_back(cyc);
      end
      if (io.res_valid && io.res_ready) begin
        rd_q.push_back(io.res_data);
        rc_q.push_back(io.res_cycles);
        rt_q.push_back(io.res_timeout);
      end
    end
  end

  function automatic logic [63:0] m3(longint v);
    return 64'(-3 * v);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input longint v);
    int n;
    n = 0;
    @(negedge clk);
    while (!io.arg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 64'(io.arg_ready), 64'd1);
    io.arg_valid = 1'b1;
    io.arg_data  = v;
    @(negedge clk);
    io.arg_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k;
    k = 0;
    while (rd_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wait_res", 64'(rd_q.size()), 64'(n));
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!io.res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid", 64'(io.res_valid), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_arg_ready"}, 64'(io.arg_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(io.res_valid), 64'd0);
    check({tag, "_res_data"}, io.res_data, 64'd0);
    check({tag, "_res_to"}, 64'(io.res_timeout), 64'd0);
    check({tag, "_res_cyc"}, 64'(io.res_cycles), 64'd0);
    check({tag, "_busy"}, 64'(io.busy), 64'd0);
    check({tag, "_r_en"}, 64'(io.k_r_enable), 64'd0);
    check({tag, "_init"}, io.k_init_i, 64'd0);
    check({tag, "_occ"}, 64'(dut.occ), 64'd0);
  endtask

  initial begin
    int pc;
    reset        = 1'b1;
    io.arg_valid = 1'b0;
    io.arg_data  = '0;
    io.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    reset = 1'b0;

    // Single call, result left pending to check the hold behaviour.
    push(64'hffff_ffff_ffff_fff9);
    pc = cyc;
    wait_valid();
    check("t1_data", io.res_data, 64'd21);
    check("t1_cyc", 64'(io.res_cycles), 64'd5);
    check("t1_to", 64'(io.res_timeout), 64'd0);
    check("t1_init", io.k_init_i, 64'hffff_ffff_ffff_fff9);
    check("t1_nlaunch", 64'(la_q.size()), 64'd1);
    check("t1_latency", 64'(lc_q[0] - pc), 64'd1);
    repeat (3) @(negedge clk);
    check("t1_hold_v", 64'(io.res_valid), 64'd1);
    check("t1_hold_d", io.res_data, 64'd21);

    // Fill the FIFO behind the pending result; a fifth push is refused.
    k_rise_at = 1;
    push(1); push(2); push(3); push(4);
    check("t2_full_rdy", 64'(io.arg_ready), 64'd0);
    check("t2_occ", 64'(dut.occ), 64'd4);
    check("t2_busy", 64'(io.busy), 64'd1);
    @(negedge clk);
    io.arg_valid = 1'b1;
    io.arg_data  = 64'd99;
    @(negedge clk);
    io.arg_valid = 1'b0;
    check("t2_occ_after5", 64'(dut.occ), 64'd4);
    io.res_ready = 1'b1;
    wait_res(5);
    check("t2_r0", rd_q[0], 64'd21);
    for (int i = 1; i <= 4; i++) begin
      check("t2_res", rd_q[i], m3(i));
      check("t2_arg", la_q[i], 64'(i));
      check("t2_cyc", 64'(rc_q[i]), 64'd1);
    end
    for (int i = 2; i <= 4; i++) check("t2_space", 64'(lc_q[i] - lc_q[i-1]), 64'd4);
    repeat (10) @(negedge clk);
    check("t2_nlaunch", 64'(la_q.size()), 64'd5);

    // Push and pop in the same cycle at occupancy 2.
    io.res_ready = 1'b0;
    push(20);
    wait_valid();
    push(21);
    push(22);
    check("t3_occ_pre", 64'(dut.occ), 64'd2);
    io.res_ready = 1'b1;
    @(negedge clk);
    check("t3_idle", 64'(io.res_valid), 64'd0);
    io.arg_valid = 1'b1;
    io.arg_data  = 64'd23;
    @(negedge clk);
    io.arg_valid = 1'b0;
    check("t3_occ_same", 64'(dut.occ), 64'd2);
    check("t3_launch", 64'(io.k_r_enable), 64'd1);
    wait_res(9);
    for (int i = 0; i < 4; i++) begin
      check("t3_res", rd_q[5+i], m3(20 + i));
      check("t3_arg", la_q[5+i], 64'(20 + i));
    end

    // Hung kernel, then a normal call.
    k_rise_at = 0;
    push(5);
    wait_res(10);
    check("t4_to_data", rd_q[9], 64'd0);
    check("t4_to_flag", 64'(rt_q[9]), 64'd1);
    check("t4_to_cyc", 64'(rc_q[9]), 64'd16);
    k_rise_at = 5;
    push(6);
    wait_res(11);
    check("t4_next_data", rd_q[10], m3(6));
    check("t4_next_flag", 64'(rt_q[10]), 64'd0);
    check("t4_next_cyc", 64'(rc_q[10]), 64'd5);

    // Done already high at launch: only the later rising edge counts.
    k_pre_high = 1'b1;
    k_drop_at  = 2;
    k_rise_at  = 5;
    push(7);
    wait_res(12);
    check("t5_data", rd_q[11], m3(7));
    check("t5_cyc", 64'(rc_q[11]), 64'd5);
    check("t5_flag", 64'(rt_q[11]), 64'd0);
    k_pre_high = 1'b0;
    k_drop_at  = 0;
    k_rise_at  = 1;

    // Pointer wrap across 3*DEPTH calls.
    for (int i = 0; i < 3 * DEPTH; i++) push(100 + i);
    wait_res(24);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      check("t6_res", rd_q[12+i], m3(100 + i));
      check("t6_arg", la_q[12+i], 64'(100 + i));
    end
    check("t6_nlaunch", 64'(la_q.size()), 64'd24);

    // Reset in the middle of a call with two args queued.
    k_rise_at = 0;
    push(8);
    push(9);
    push(10);
    check("t7_occ_pre", 64'(dut.occ), 64'd2);
    check("t7_launched", 64'(la_q.size()), 64'd25);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst1");
    repeat (40) @(negedge clk);
    check("t7_no_launch", 64'(la_q.size()), 64'd25);
    check("t7_no_res", 64'(rd_q.size()), 64'd24);
    check("t7_idle_v", 64'(io.res_valid), 64'd0);
    check("t7_idle_busy", 64'(io.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
